// File: rtl/arduboy_pkg.sv
// Shared definitions for the Arduboy core: EEPROM save sequencer states and
// sector/ext-port geometry.
package arduboy_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned EXT_ADDR_W   = 17;
    localparam int unsigned SECTOR_W     = EXT_ADDR_W - 9;
    localparam int unsigned AUTOSAVE_W   = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_REQ,
        ST_XFER,
        ST_NEXT,
        ST_DONE
    } eep_state_t;

    // Index of the last sector to restore: min(eep_sectors, ceil(img_size/512)) - 1.
    function automatic logic [SECTOR_W-1:0] load_last_sector(input logic [31:0] img_size,
                                                             input int unsigned eep_sectors);
        logic [32:0] img_sectors;
        img_sectors = ({1'b0, img_size} + 33'd511) >> 9;
        if (img_sectors > 33'(eep_sectors))
            img_sectors = 33'(eep_sectors);
        return SECTOR_W'(img_sectors - 33'd1);
    endfunction

endpackage

// File: rtl/eep_autosave_timer.sv
// Autosave down-counter: reloads on every CPU EEPROM write and pulses expire
// on the enabled clock that takes it to zero.
module eep_autosave_timer
    import arduboy_pkg::*;
#(
    parameter logic [AUTOSAVE_W-1:0] CYCLES = 24'd10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [AUTOSAVE_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (load)
            count <= CYCLES;
        else if (en && count != '0)
            count <= count - AUTOSAVE_W'(1);
    end

    assign expire = en && !load && (count == AUTOSAVE_W'(1));

endmodule

// File: rtl/eep_save_ctrl.sv
// Bulk EEPROM load/save sequencer between the EEPROM ext port and the HPS
// sector interface; holds the AVR core off the EEPROM for each transfer.
module eep_save_ctrl
    import arduboy_pkg::*;
#(
    parameter int unsigned           EEP_SIZE        = 512,
    parameter logic [AUTOSAVE_W-1:0] AUTOSAVE_CYCLES = 24'd10_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  img_mounted,
    input  logic [31:0]           img_size,
    input  logic                  save_req,
    input  logic                  autosave_en,
    input  logic                  cpu_eep_wr,
    input  logic                  eep_busy,
    output logic                  cpu_hold,
    output logic                  ext_eep_en,
    output logic                  ext_eep_rd,
    output logic                  ext_eep_wr,
    output logic [EXT_ADDR_W-1:0] ext_eep_addr,
    output logic [7:0]            ext_eep_dout,
    input  logic [7:0]            ext_eep_din,
    output logic [31:0]           sd_lba,
    output logic                  sd_rd,
    output logic                  sd_wr,
    input  logic                  sd_ack,
    input  logic [8:0]            sd_buff_addr,
    input  logic [7:0]            sd_buff_dout,
    input  logic                  sd_buff_wr,
    output logic [7:0]            sd_buff_din,
    output logic                  busy,
    output logic                  dirty
);

    localparam int unsigned          EEP_SECTORS = EEP_SIZE / SECTOR_BYTES;
    localparam logic [SECTOR_W-1:0]  SAVE_LAST   = SECTOR_W'(EEP_SECTORS - 1);

    eep_state_t            state, state_next;
    logic [SECTOR_W-1:0]   sector, op_last, load_last;
    logic                  op_save;
    logic                  load_pend, save_pend, mounted, ack_q;
    logic                  mount_nz, mount_zero, save_in, autosave_expire;
    logic                  take_load, take_save, drop_save;
    logic                  eep_window, xfer;

    assign mount_nz   = img_mounted && (img_size != '0);
    assign mount_zero = img_mounted && (img_size == '0);
    assign save_in    = save_req || autosave_expire;

    // New pulses are acted on directly from IDLE; anything else is latched one deep.
    always_comb begin
        take_load = 1'b0;
        take_save = 1'b0;
        drop_save = 1'b0;
        if (state == ST_IDLE) begin
            take_load = (load_pend && !mount_zero) || mount_nz;
            take_save = !take_load && (save_pend || save_in) && mounted;
            drop_save = !take_load && (save_pend || save_in) && !mounted;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (take_load || take_save) state_next = ST_GRANT;
            ST_GRANT: if (!eep_busy)              state_next = ST_REQ;
            ST_REQ:   if (sd_ack && !ack_q)       state_next = ST_XFER;
            ST_XFER:  if (!sd_ack)                state_next = ST_NEXT;
            ST_NEXT:  state_next = (sector == op_last) ? ST_DONE : ST_REQ;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            sector    <= '0;
            op_last   <= '0;
            load_last <= '0;
            op_save   <= 1'b0;
            load_pend <= 1'b0;
            save_pend <= 1'b0;
            mounted   <= 1'b0;
            dirty     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state <= state_next;
            ack_q <= sd_ack;

            if (mount_nz) begin
                load_last <= load_last_sector(img_size, EEP_SECTORS);
                mounted   <= 1'b1;
            end else if (mount_zero) begin
                mounted   <= 1'b0;
            end

            load_pend <= mount_zero ? 1'b0 : ((load_pend || mount_nz) && !take_load);
            save_pend <= (save_pend || save_in) && !take_save && !drop_save;

            if (take_load) begin
                op_save <= 1'b0;
                op_last <= mount_nz ? load_last_sector(img_size, EEP_SECTORS) : load_last;
                sector  <= '0;
            end else if (take_save) begin
                op_save <= 1'b1;
                op_last <= SAVE_LAST;
                sector  <= '0;
            end else if (state == ST_NEXT && sector != op_last) begin
                sector  <= sector + SECTOR_W'(1);
            end

            if (take_save || (state == ST_DONE && !op_save))
                dirty <= 1'b0;
            else if (cpu_eep_wr)
                dirty <= 1'b1;
        end
    end

    eep_autosave_timer #(
        .CYCLES(AUTOSAVE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (cpu_eep_wr),
        .en     (dirty && autosave_en && mounted && (state == ST_IDLE)),
        .expire (autosave_expire)
    );

    assign eep_window   = (state == ST_REQ) || (state == ST_XFER) || (state == ST_NEXT);
    assign cpu_hold     = (state == ST_GRANT) || eep_window;
    assign ext_eep_en   = eep_window && !eep_busy && cpu_hold;
    assign xfer         = (state == ST_XFER) && ext_eep_en;
    assign ext_eep_wr   = xfer && !op_save && sd_buff_wr;
    assign ext_eep_rd   = xfer && op_save;
    assign ext_eep_addr = {sector, sd_buff_addr};
    assign ext_eep_dout = sd_buff_dout;
    assign sd_buff_din  = ext_eep_din;
    assign sd_rd        = (state == ST_REQ) && !op_save;
    assign sd_wr        = (state == ST_REQ) && op_save;
    assign sd_lba       = {{(32 - SECTOR_W){1'b0}}, sector};
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_eep_save_ctrl.sv
// Directed bench for eep_save_ctrl with an EEPROM model, an HPS sector model
// and a byte scoreboard for saved data.
module tb_eep_save_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        img_mounted = 1'b0;
    logic [31:0] img_size = '0;
    logic        save_req = 1'b0;
    logic        autosave_en = 1'b0;
    logic        cpu_eep_wr = 1'b0;
    logic        eep_busy = 1'b0;
    logic        cpu_hold, ext_eep_en, ext_eep_rd, ext_eep_wr;
    logic [16:0] ext_eep_addr;
    logic [7:0]  ext_eep_dout;
    logic [7:0]  ext_eep_din;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack = 1'b0;
    logic [8:0]  sd_buff_addr = '0;
    logic [7:0]  sd_buff_dout = '0;
    logic        sd_buff_wr = 1'b0;
    logic [7:0]  sd_buff_din;
    logic        busy, dirty;

    logic        cpu_wr_en = 1'b0;
    logic [9:0]  cpu_wr_addr = '0;
    logic [7:0]  cpu_wr_data = '0;

    logic [7:0]  mem [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic [7:0]  exp_q [$];
    int          checks = 0;
    int          errors = 0;

    eep_save_ctrl #(
        .EEP_SIZE(1024),
        .AUTOSAVE_CYCLES(24'd100)
    ) dut (
        .clk(clk), .rst(rst), .img_mounted(img_mounted), .img_size(img_size),
        .save_req(save_req), .autosave_en(autosave_en), .cpu_eep_wr(cpu_eep_wr),
        .eep_busy(eep_busy), .cpu_hold(cpu_hold), .ext_eep_en(ext_eep_en),
        .ext_eep_rd(ext_eep_rd), .ext_eep_wr(ext_eep_wr), .ext_eep_addr(ext_eep_addr),
        .ext_eep_dout(ext_eep_dout), .ext_eep_din(ext_eep_din), .sd_lba(sd_lba),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .busy(busy), .dirty(dirty)
    );

    always #5 clk = ~clk;

    // EEPROM model: registered read, writes from the ext port or the CPU side.
    always @(posedge clk) begin
        if (ext_eep_en && ext_eep_wr) mem[ext_eep_addr[9:0]] <= ext_eep_dout;
        if (cpu_wr_en) mem[cpu_wr_addr] <= cpu_wr_data;
        if (ext_eep_en && ext_eep_rd) ext_eep_din <= mem[ext_eep_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ext_eep_en === 1'b1) begin
            chk("en_needs_hold", cpu_hold, 1);
            chk("en_while_eep_busy", eep_busy, 0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int s, input int i, input int seed);
        return 8'(s * 37 + i * 11 + seed * 5 + 3);
    endfunction

    task automatic wait_for(input bit want_wr, input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            if ((want_wr ? sd_wr : sd_rd) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic wait_idle(input int limit);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        chk("idle_timeout", ok, 1);
    endtask

    task automatic cpu_write(input int addr, input logic [7:0] data);
        cpu_wr_addr = 10'(addr);
        cpu_wr_data = data;
        cpu_wr_en   = 1'b1;
        cpu_eep_wr  = 1'b1;
        ref_mem[addr] = data;
        tick;
        cpu_wr_en  = 1'b0;
        cpu_eep_wr = 1'b0;
    endtask

    task automatic mount(input logic [31:0] size);
        img_size    = size;
        img_mounted = 1'b1;
        tick;
        img_mounted = 1'b0;
    endtask

    task automatic hps_load(input int nsec, input int seed, input int save_at);
        bit ok;
        for (int s = 0; s < nsec; s++) begin
            wait_for(1'b0, 40, ok);
            chk("load_req_timeout", ok, 1);
            if (!ok) return;
            chk("load_lba", sd_lba, 32'(s));
            chk("load_no_wr", sd_wr, 0);
            chk("load_hold", cpu_hold, 1);
            sd_ack = 1'b1;
            tick;
            chk("load_req_drop", sd_rd, 0);
            for (int i = 0; i < 512; i++) begin
                logic [7:0] d;
                d = (s == 0 && i == 5) ? 8'hA5 : pat(s, i, seed);
                sd_buff_addr = 9'(i);
                sd_buff_dout = d;
                sd_buff_wr   = 1'b1;
                save_req     = (s == 0 && i == save_at);
                ref_mem[s * 512 + i] = d;
                tick;
            end
            sd_buff_wr = 1'b0;
            save_req   = 1'b0;
            sd_ack     = 1'b0;
            tick;
        end
    endtask

    task automatic hps_save(input int nsec);
        bit ok;
        for (int s = 0; s < nsec; s++) begin
            wait_for(1'b1, 40, ok);
            chk("save_req_timeout", ok, 1);
            if (!ok) return;
            chk("save_lba", sd_lba, 32'(s));
            chk("save_no_rd", sd_rd, 0);
            sd_ack = 1'b1;
            tick;
            chk("save_req_drop", sd_wr, 0);
            for (int i = 0; i <= 512; i++) begin
                if (i > 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk((i == 512) ? "save_last_byte" : "save_byte", sd_buff_din, e);
                end
                if (i < 512) begin
                    sd_buff_addr = 9'(i);
                    exp_q.push_back(ref_mem[s * 512 + i]);
                end
                tick;
            end
            sd_ack = 1'b0;
            tick;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;

        tick;
        tick;
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dirty", dirty, 0);
        chk("rst_sd_rd", sd_rd, 0);
        chk("rst_sd_wr", sd_wr, 0);
        chk("rst_eep_en", ext_eep_en, 0);
        chk("rst_eep_rdwr", {ext_eep_rd, ext_eep_wr}, 0);
        chk("rst_lba", sd_lba, 0);
        rst = 1'b1;
        tick;

        // Unmounted CPU write marks dirty; a 512-byte mount restores one sector.
        cpu_write(3, 8'h11);
        chk("dirty_set", dirty, 1);
        mount(32'd512);
        chk("grant_next_cycle", cpu_hold, 1);
        chk("grant_no_en", ext_eep_en, 0);
        hps_load(1, 1, -1);
        wait_idle(10);
        chk("load1_dirty_clr", dirty, 0);
        chk("load1_hold_released", cpu_hold, 0);
        chk("eep_byte5", mem[5], 8'hA5);
        for (int k = 0; k < 10; k++) tick;
        chk("load1_one_sector", sd_rd, 0);

        // 1000-byte image restores two sectors.
        mount(32'd1000);
        hps_load(2, 2, -1);
        wait_idle(10);
        chk("eep_byte_s1", mem[600], pat(1, 88, 2));

        // Zero-size mount: no load, unmounted, save ignored, dirty kept.
        mount(32'd0);
        wait_for(1'b0, 10, ok);
        chk("no_load_size0", ok, 0);
        chk("size0_idle", busy, 0);
        cpu_write(8, 8'h22);
        save_req = 1'b1;
        tick;
        save_req = 1'b0;
        wait_for(1'b1, 10, ok);
        chk("save_ignored_unmounted", ok, 0);
        chk("dirty_kept", dirty, 1);

        mount(32'd1024);
        hps_load(2, 3, -1);
        wait_idle(10);
        chk("load2_dirty_clr", dirty, 0);

        // OSD save of a CPU-written byte at the top of sector 0.
        cpu_write(511, 8'h3C);
        save_req = 1'b1;
        tick;
        save_req = 1'b0;
        chk("save_grant", busy, 1);
        chk("save_dirty_clr", dirty, 0);
        hps_save(2);
        wait_idle(10);

        // Autosave after 100 idle cycles, then a mid-count write pushes it out.
        autosave_en = 1'b1;
        cpu_write(700, 8'h5A);
        n = 1;
        while (sd_wr !== 1'b1 && n < 300) begin
            tick;
            n++;
        end
        checks++;
        assert (n >= 98 && n <= 102) else begin
            errors++;
            $error("FAIL autosave_delay observed=%0d expected=98..102", n);
        end
        hps_save(2);
        wait_idle(10);

        cpu_write(701, 8'h6B);
        n = 1;
        while (sd_wr !== 1'b1 && n < 300) begin
            if (n == 50) cpu_write(702, 8'h7C);
            else tick;
            n++;
        end
        checks++;
        assert (n >= 148 && n <= 152) else begin
            errors++;
            $error("FAIL autosave_retrigger observed=%0d expected=148..152", n);
        end
        hps_save(2);
        wait_idle(10);
        autosave_en = 1'b0;

        // eep_busy holds the grant off the ext port and the HPS.
        eep_busy = 1'b1;
        save_req = 1'b1;
        tick;
        save_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("busy_hold", cpu_hold, 1);
            chk("busy_no_en", ext_eep_en, 0);
            chk("busy_no_wr", sd_wr, 0);
            if (k == 3) eep_busy = 1'b0;
            tick;
        end
        hps_save(2);
        wait_idle(10);

        // Save requested mid-load runs right after the load.
        mount(32'd512);
        hps_load(1, 5, 100);
        hps_save(2);
        wait_idle(10);

        // Same-cycle mount and save from the unmounted state: load then save.
        mount(32'd0);
        img_size    = 32'd512;
        img_mounted = 1'b1;
        save_req    = 1'b1;
        tick;
        img_mounted = 1'b0;
        save_req    = 1'b0;
        hps_load(1, 7, -1);
        hps_save(2);
        wait_idle(10);

        // Asynchronous reset in the middle of a save transfer.
        save_req = 1'b1;
        tick;
        save_req = 1'b0;
        wait_for(1'b1, 40, ok);
        chk("rst_save_req_timeout", ok, 1);
        sd_ack = 1'b1;
        tick;
        sd_buff_addr = 9'd0;
        cpu_eep_wr = 1'b1;
        tick;
        cpu_eep_wr = 1'b0;
        sd_buff_addr = 9'd1;
        tick;
        chk("pre_rst_dirty", dirty, 1);
        chk("pre_rst_hold", cpu_hold, 1);
        chk("pre_rst_en", ext_eep_en, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_sd_wr", sd_wr, 0);
        chk("async_hold", cpu_hold, 0);
        chk("async_eep_en", ext_eep_en, 0);
        chk("async_busy", busy, 0);
        sd_ack = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        tick;
        chk("post_rst_idle", busy, 0);
        chk("post_rst_dirty", dirty, 0);
        chk("post_rst_lba", sd_lba, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
